// File: rtl/cp0_intc.sv
// CP0 interrupt/exception controller: SR, Cause, EPC, PRId; CP0_COUNT_EN adds Count/Compare timer on IP[15].
// Latency: int_req and cp0_rdata are combinational; register state updates on the next rising edge.
// Backpressure: none; a pending int_req discards a coincident mtc0 write.
module cp0_intc #(
   parameter int unsigned        NUM_IRQ   = 3,
   parameter logic [NUM_IRQ-1:0] IRQ_LATCH = '1,
   parameter logic [31:0]        PRID      = 32'h2020_0007
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] hw_int,
   input  logic               exc_valid,
   input  logic [4:0]         exc_code,
   input  logic [31:0]        victim_pc,
   input  logic               victim_bd,
   input  logic [4:0]         cp0_addr,
   input  logic [31:0]        cp0_wdata,
   input  logic               cp0_we,
   input  logic               eret,
   output logic [31:0]        cp0_rdata,
   output logic [31:0]        epc,
   output logic               int_req
);

   typedef enum logic {ST_RUN = 1'b0, ST_HANDLER = 1'b1} state_t;

   localparam logic [4:0] A_COUNT   = 5'd9;
   localparam logic [4:0] A_COMPARE = 5'd11;
   localparam logic [4:0] A_SR      = 5'd12;
   localparam logic [4:0] A_CAUSE   = 5'd13;
   localparam logic [4:0] A_EPC     = 5'd14;
   localparam logic [4:0] A_PRID    = 5'd15;

   localparam logic [5:0] EXT_MASK = 6'((7'd1 << NUM_IRQ) - 7'd1);
`ifdef CP0_COUNT_EN
   localparam logic [5:0] IM_MASK = EXT_MASK | 6'h20;
`else
   localparam logic [5:0] IM_MASK = EXT_MASK;
`endif

   state_t             state_q, state_d;
   logic [5:0]         im_q, im_d;
   logic               ie_q, ie_d;
   logic               bd_q, bd_d;
   logic [4:0]         exc_code_q, exc_code_d;
   logic [31:0]        epc_q, epc_d;
   logic [NUM_IRQ-1:0] ip_q, ip_d;
   logic [NUM_IRQ-1:0] hw_prev_q, hw_prev_d;
`ifdef CP0_COUNT_EN
   logic [31:0]        count_q, count_d;
   logic [31:0]        compare_q, compare_d;
   logic               ip_tmr_q, ip_tmr_d;
`endif

   logic [5:0] ip_all;
   logic       exl;
   logic       irq_pend;
   logic       wr;

   always_comb begin
      ip_all = '0;
      ip_all[NUM_IRQ-1:0] = ip_q;
`ifdef CP0_COUNT_EN
      ip_all[5] = ip_tmr_q;
`endif
   end

   assign exl      = (state_q == ST_HANDLER);
   assign irq_pend = ie_q & |(ip_all & im_q);
   // Gated by reset so a live exc_valid cannot leak a request out while held in reset.
   assign int_req  = reset & ~exl & (exc_valid | irq_pend);
   assign wr       = cp0_we & ~int_req;
   assign epc      = epc_q;

   always_comb begin
      state_d    = state_q;
      im_d       = im_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      hw_prev_d  = hw_int;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (IRQ_LATCH[i])
            ip_d[i] = (ip_q[i] & ~(wr && cp0_addr == A_CAUSE && cp0_wdata[10+i]))
                      | (hw_int[i] & ~hw_prev_q[i]);
         else
            ip_d[i] = hw_int[i];
      end
      if (wr && cp0_addr == A_SR) begin
         im_d = cp0_wdata[15:10] & IM_MASK;
         ie_d = cp0_wdata[0];
      end
      if (wr && cp0_addr == A_EPC)
         epc_d = cp0_wdata;
      if (int_req)
         state_d = ST_HANDLER;
      else if (eret)
         state_d = ST_RUN;
      else if (wr && cp0_addr == A_SR)
         state_d = state_t'(cp0_wdata[1]);
      if (int_req) begin
         bd_d       = victim_bd;
         epc_d      = victim_bd ? victim_pc - 32'd4 : victim_pc;
         exc_code_d = irq_pend ? 5'd0 : exc_code;
      end
`ifdef CP0_COUNT_EN
      count_d   = (wr && cp0_addr == A_COUNT) ? cp0_wdata : count_q + 32'd1;
      compare_d = (wr && cp0_addr == A_COMPARE) ? cp0_wdata : compare_q;
      ip_tmr_d  = (wr && cp0_addr == A_COMPARE) ? 1'b0 : (ip_tmr_q | (count_q == compare_q));
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         im_q       <= '0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         exc_code_q <= '0;
         epc_q      <= '0;
         ip_q       <= '0;
         hw_prev_q  <= '0;
`ifdef CP0_COUNT_EN
         count_q    <= '0;
         compare_q  <= '0;
         ip_tmr_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         im_q       <= im_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
         ip_q       <= ip_d;
         hw_prev_q  <= hw_prev_d;
`ifdef CP0_COUNT_EN
         count_q    <= count_d;
         compare_q  <= compare_d;
         ip_tmr_q   <= ip_tmr_d;
`endif
      end
   end

   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         A_SR:    cp0_rdata = {16'd0, im_q, 8'd0, exl, ie_q};
         A_CAUSE: cp0_rdata = {bd_q, 15'd0, ip_all, 3'd0, exc_code_q, 2'd0};
         A_EPC:   cp0_rdata = epc_q;
         A_PRID:  cp0_rdata = PRID;
`ifdef CP0_COUNT_EN
         A_COUNT:   cp0_rdata = count_q;
         A_COMPARE: cp0_rdata = compare_q;
`endif
         default: cp0_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc (default build): line 2 configured level, lines 0/1 sticky.
module tb_cp0_intc;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  hw_int;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] victim_pc;
   logic        victim_bd;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic        cp0_we;
   logic        eret;
   logic [31:0] cp0_rdata;
   logic [31:0] epc;
   logic        int_req;

   int checks   = 0;
   int failures = 0;

   cp0_intc #(.NUM_IRQ(3), .IRQ_LATCH(3'b011), .PRID(32'h2020_0007)) dut (
      .clk(clk), .reset(reset), .hw_int(hw_int), .exc_valid(exc_valid),
      .exc_code(exc_code), .victim_pc(victim_pc), .victim_bd(victim_bd),
      .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_we(cp0_we), .eret(eret),
      .cp0_rdata(cp0_rdata), .epc(epc), .int_req(int_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
      cp0_addr = a;
      #1;
      chk(tag, cp0_rdata, exp);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      cp0_addr  = a;
      cp0_wdata = d;
      cp0_we    = 1'b1;
      step();
      cp0_we    = 1'b0;
   endtask

   initial begin
      reset = 1'b0; hw_int = '0; exc_valid = 1'b1; exc_code = '0; victim_pc = '0;
      victim_bd = 1'b0; cp0_addr = '0; cp0_wdata = '0; cp0_we = 1'b0; eret = 1'b0;
      #2;
      chk("rst_int_req", {31'd0, int_req}, 32'd0);
      chk("rst_epc", epc, 32'd0);
      rd(5'd15, 32'h2020_0007, "rst_prid");
      rd(5'd12, 32'd0, "rst_sr");
      exc_valid = 1'b0;
      step(); step();
      reset = 1'b1;
      step();

      // Sticky IRQ taken once, lands in handler.
      wr(5'd12, 32'h0000_0401);
      rd(5'd12, 32'h0000_0401, "sr_write");
      hw_int[0] = 1'b1; victim_pc = 32'h3000;
      #1 chk("irq_pre", {31'd0, int_req}, 32'd0);
      step();
      hw_int[0] = 1'b0;
      #1 chk("irq_req", {31'd0, int_req}, 32'd1);
      rd(5'd13, 32'h0000_0400, "irq_ip");
      step();
      chk("irq_once", {31'd0, int_req}, 32'd0);
      rd(5'd12, 32'h0000_0403, "irq_exl");
      chk("irq_epc", epc, 32'h3000);
      rd(5'd13, 32'h0000_0400, "irq_cause");
      step();
      rd(5'd13, 32'h0000_0400, "ip_sticky");
      wr(5'd13, 32'h0000_0400);
      rd(5'd13, 32'd0, "ip_w1c");

      // IP updates in handler; eret re-enables the pending request.
      hw_int[0] = 1'b1;
      step();
      hw_int[0] = 1'b0;
      #1 chk("hdl_no_req", {31'd0, int_req}, 32'd0);
      rd(5'd13, 32'h0000_0400, "hdl_ip");
      eret = 1'b1;
      step();
      eret = 1'b0; victim_pc = 32'h3100;
      rd(5'd12, 32'h0000_0401, "eret_exl");
      chk("eret_irq", {31'd0, int_req}, 32'd1);
      chk("eret_epc", epc, 32'h3000);
      step();
      rd(5'd12, 32'h0000_0403, "reirq_exl");
      chk("reirq_epc", epc, 32'h3100);
      cp0_addr = 5'd13; cp0_wdata = 32'h0000_0400; cp0_we = 1'b1; eret = 1'b1;
      step();
      cp0_we = 1'b0; eret = 1'b0;
      rd(5'd12, 32'h0000_0401, "eret_w1c_sr");
      rd(5'd13, 32'd0, "eret_w1c_cause");
      chk("idle_req", {31'd0, int_req}, 32'd0);

      // Exception in delay slot with IE=0; coincident mtc0 EPC discarded.
      wr(5'd12, 32'h0000_0400);
      exc_valid = 1'b1; exc_code = 5'd12; victim_pc = 32'h3010; victim_bd = 1'b1;
      cp0_addr = 5'd14; cp0_wdata = 32'hDEAD_BEEF; cp0_we = 1'b1;
      #1 chk("exc_req", {31'd0, int_req}, 32'd1);
      step();
      exc_valid = 1'b0; victim_bd = 1'b0; cp0_we = 1'b0;
      #1 chk("exc_epc_bd", epc, 32'h300C);
      rd(5'd13, 32'h8000_0030, "exc_cause");
      rd(5'd12, 32'h0000_0402, "exc_sr");

      // eret beats SR write of EXL; other SR fields take written values.
      cp0_addr = 5'd12; cp0_wdata = 32'h0000_0403; cp0_we = 1'b1; eret = 1'b1;
      step();
      cp0_we = 1'b0; eret = 1'b0;
      rd(5'd12, 32'h0000_0401, "eret_sr_wins");
      wr(5'd14, 32'h1234_5678);
      chk("epc_mtc0", epc, 32'h1234_5678);

      // Interrupt has priority over a same-cycle exception.
      hw_int[0] = 1'b1;
      step();
      hw_int[0] = 1'b0; exc_valid = 1'b1; exc_code = 5'd4; victim_pc = 32'h4000;
      #1 chk("prio_req", {31'd0, int_req}, 32'd1);
      step();
      chk("exc_in_hdl", {31'd0, int_req}, 32'd0);
      rd(5'd13, 32'h0000_0400, "prio_cause");
      chk("prio_epc", epc, 32'h4000);
      exc_valid = 1'b0;

      // Level line 2 follows input and ignores W1C.
      hw_int[2] = 1'b1;
      step();
      rd(5'd13, 32'h0000_1400, "lvl_ip");
      cp0_addr = 5'd13; cp0_wdata = 32'h0000_1400; cp0_we = 1'b1;
      step();
      cp0_we = 1'b0; hw_int[2] = 1'b0;
      rd(5'd13, 32'h0000_1000, "lvl_w1c");
      step();
      rd(5'd13, 32'd0, "lvl_drop");

      // Edge set wins over same-cycle W1C.
      hw_int[1] = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'h0000_0800; cp0_we = 1'b1;
      step();
      cp0_we = 1'b0;
      rd(5'd13, 32'h0000_0800, "set_wins");
      wr(5'd13, 32'h0000_0800);
      rd(5'd13, 32'd0, "w1c_line1");
      hw_int[1] = 1'b0;

      // Timer registers absent; IM limited to implemented lines.
      rd(5'd9, 32'd0, "count_absent");
      wr(5'd11, 32'hFFFF_FFFF);
      rd(5'd11, 32'd0, "compare_absent");
      rd(5'd3, 32'd0, "unmapped");
      wr(5'd12, 32'h0000_FC03);
      rd(5'd12, 32'h0000_1C03, "im_mask");

      // Asynchronous reset mid-handler.
      hw_int[0] = 1'b1;
      step();
      hw_int[0] = 1'b0;
      rd(5'd13, 32'h0000_0400, "pre_rst_ip");
      chk("pre_rst_epc", epc, 32'h4000);
      #2;
      reset = 1'b0; exc_valid = 1'b1;
      #1 chk("arst_int_req", {31'd0, int_req}, 32'd0);
      chk("arst_epc", epc, 32'd0);
      rd(5'd12, 32'd0, "arst_sr");
      rd(5'd13, 32'd0, "arst_cause");
      step();
      reset = 1'b1; exc_valid = 1'b0;
      step();
      rd(5'd12, 32'd0, "post_rst_sr");
      chk("post_rst_req", {31'd0, int_req}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
